// File: rtl/fp16_entry_pkg.sv
// fp16_entry_pkg: definitions shared by the FP16 keypad entry block.
//   state_e        - entry FSM states
//   KEY_CLEAR      - scan code of the CLEAR key (BACKSPACE when ENTRY_BACKSPACE_EN)
//   KEY_ENTER      - scan code of the ENTER key
//   BLANK_SEG      - active-low pattern for a dark digit
//   key_to_nibble  - scan code -> hex nibble for the digit keys
//   key_is_digit   - 1 for every code that carries a nibble
package fp16_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_FULL,
    ST_HOLD
  } state_e;

  localparam logic [3:0] KEY_CLEAR = 4'd12;
  localparam logic [3:0] KEY_ENTER = 4'd14;
  localparam logic [6:0] BLANK_SEG = 7'h7F;

  // 4x4 keypad: the first three columns of rows 0..2 are 1..9, the last
  // column is A..C, and the bottom row carries 0 and D.
  function automatic logic [3:0] key_to_nibble(input logic [3:0] code);
    logic [3:0] nib;
    case (code)
      4'd0:    nib = 4'h1;
      4'd1:    nib = 4'h2;
      4'd2:    nib = 4'h3;
      4'd3:    nib = 4'hA;
      4'd4:    nib = 4'h4;
      4'd5:    nib = 4'h5;
      4'd6:    nib = 4'h6;
      4'd7:    nib = 4'hB;
      4'd8:    nib = 4'h7;
      4'd9:    nib = 4'h8;
      4'd10:   nib = 4'h9;
      4'd11:   nib = 4'hC;
      4'd13:   nib = 4'h0;
      4'd15:   nib = 4'hD;
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

  function automatic logic key_is_digit(input logic [3:0] code);
    return (code != KEY_CLEAR) && (code != KEY_ENTER);
  endfunction

endpackage

// File: rtl/fp16_keypad_entry_if.sv
// fp16_keypad_entry_if: key input and operand handshake of fp16_keypad_entry.
//   key_valid/key_code - keypad strobe and scan index (driven by master)
//   word_ready         - consumer accepts the held operand (driven by master)
//   word_valid/word    - assembled operand and its valid flag (driven by slave)
//   digit_count        - nibbles entered so far, 0..4 (driven by slave)
//   err                - one-cycle pulse for a rejected key (driven by slave)
interface fp16_keypad_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        word_ready;
  logic        word_valid;
  logic [15:0] word;
  logic [2:0]  digit_count;
  logic        err;

  modport master (
    output key_valid, key_code, word_ready,
    input  word_valid, word, digit_count, err
  );

  modport slave (
    input  key_valid, key_code, word_ready,
    output word_valid, word, digit_count, err
  );
endinterface

// File: rtl/seg7_hex_encoder.sv
// seg7_hex_encoder: combinational hex nibble -> 7-segment pattern.
//   nibble - value to show (0..F, shown as 0-9 A b C d E F)
//   blank  - 1 forces the digit dark
//   seg    - active-low segments {g,f,e,d,c,b,a}
module seg7_hex_encoder
  import fp16_entry_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = BLANK_SEG;
    if (!blank) begin
      case (nibble)
        4'h0: seg = 7'h40;
        4'h1: seg = 7'h79;
        4'h2: seg = 7'h24;
        4'h3: seg = 7'h30;
        4'h4: seg = 7'h19;
        4'h5: seg = 7'h12;
        4'h6: seg = 7'h02;
        4'h7: seg = 7'h78;
        4'h8: seg = 7'h00;
        4'h9: seg = 7'h10;
        4'hA: seg = 7'h08;
        4'hB: seg = 7'h03;
        4'hC: seg = 7'h46;
        4'hD: seg = 7'h21;
        4'hE: seg = 7'h06;
        4'hF: seg = 7'h0E;
        default: seg = BLANK_SEG;
      endcase
    end
  end

endmodule

// File: rtl/fp16_keypad_entry.sv
// fp16_keypad_entry: assembles a 16-bit FP16 operand from hex keypad presses
// and hands it to the adder's operand latch with a valid/ready handshake.
//   clk, reset  - clock and synchronous active-high reset
//   bus (slave) - key_valid/key_code in, word_ready in,
//                 word_valid/word/digit_count/err out
//   hex3..hex0  - registered active-low segment outputs, hex3 = top nibble
// Build option: define ENTRY_BACKSPACE_EN to turn code 12 from CLEAR into
// BACKSPACE (drop the last nibble).
module fp16_keypad_entry
  import fp16_entry_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  fp16_keypad_entry_if.slave        bus,
  output logic [6:0]                hex3,
  output logic [6:0]                hex2,
  output logic [6:0]                hex1,
  output logic [6:0]                hex0
);

  state_e      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [2:0]  count_q, count_d;
  logic        word_valid_q, word_valid_d;
  logic        err_q, err_d;
  logic [6:0]  hex_q [4];
  logic [6:0]  hex_d [4];

  logic [3:0]  key_nib;
  logic        key_digit;

  assign key_nib   = key_to_nibble(bus.key_code);
  assign key_digit = key_is_digit(bus.key_code);

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    count_d      = count_q;
    word_valid_d = word_valid_q;
    err_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // ENTER/CLEAR with nothing entered are silently ignored.
        if (bus.key_valid && key_digit) begin
          word_d  = {12'h000, key_nib};
          count_d = 3'd1;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT, ST_FULL: begin
        if (bus.key_valid) begin
          if (bus.key_code == KEY_ENTER) begin
            state_d      = ST_HOLD;
            word_valid_d = 1'b1;
          end else if (bus.key_code == KEY_CLEAR) begin
`ifdef ENTRY_BACKSPACE_EN
            word_d  = word_q >> 4;
            count_d = count_q - 3'd1;
            state_d = (count_q == 3'd1) ? ST_IDLE : ST_COLLECT;
`else
            word_d  = 16'h0000;
            count_d = 3'd0;
            state_d = ST_IDLE;
`endif
          end else if (state_q == ST_FULL) begin
            err_d = 1'b1;
          end else begin
            word_d  = {word_q[11:0], key_nib};
            count_d = count_q + 3'd1;
            if (count_q == 3'd3) state_d = ST_FULL;
          end
        end
      end
      ST_HOLD: begin
        // Keys are never accepted here, even on the handshake edge.
        err_d = bus.key_valid;
        if (bus.word_ready) begin
          state_d      = ST_IDLE;
          word_d       = 16'h0000;
          count_d      = 3'd0;
          word_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Digit N is lit only once N+1 nibbles exist; the encoders look at the
  // current word so the registered display trails it by one cycle.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    seg7_hex_encoder u_enc (
      .nibble (word_q[gi*4 +: 4]),
      .blank  (count_q <= 3'(gi)),
      .seg    (hex_d[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      word_q       <= 16'h0000;
      count_q      <= 3'd0;
      word_valid_q <= 1'b0;
      err_q        <= 1'b0;
      for (int i = 0; i < 4; i++) hex_q[i] <= BLANK_SEG;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      count_q      <= count_d;
      word_valid_q <= word_valid_d;
      err_q        <= err_d;
      for (int i = 0; i < 4; i++) hex_q[i] <= hex_d[i];
    end
  end

  assign bus.word        = word_q;
  assign bus.word_valid  = word_valid_q;
  assign bus.digit_count = count_q;
  assign bus.err         = err_q;
  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];

endmodule

// File: tb/tb_fp16_keypad_entry.sv
// tb_fp16_keypad_entry: directed, self-checking bench for fp16_keypad_entry.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_fp16_keypad_entry;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] hex3, hex2, hex1, hex0;
  int checks = 0;
  int errors = 0;

  fp16_keypad_entry_if bus ();

  fp16_keypad_entry dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .hex3  (hex3),
    .hex2  (hex2),
    .hex1  (hex1),
    .hex0  (hex0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_hex(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                           input logic [6:0] e1, input logic [6:0] e0);
    check({tag, "_hex3"}, {9'd0, hex3}, {9'd0, e3});
    check({tag, "_hex2"}, {9'd0, hex2}, {9'd0, e2});
    check({tag, "_hex1"}, {9'd0, hex1}, {9'd0, e1});
    check({tag, "_hex0"}, {9'd0, hex0}, {9'd0, e0});
  endtask

  task automatic press(input logic [3:0] code);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic handshake();
    @(negedge clk);
    bus.word_ready = 1'b1;
    @(negedge clk);
    bus.word_ready = 1'b0;
  endtask

  initial begin
    bus.key_valid  = 1'b0;
    bus.key_code   = 4'd0;
    bus.word_ready = 1'b0;

    // Reset values
    do_reset();
    check("rst_word", bus.word, 16'h0000);
    check("rst_count", {13'd0, bus.digit_count}, 16'd0);
    check("rst_valid", {15'd0, bus.word_valid}, 16'd0);
    check("rst_err", {15'd0, bus.err}, 16'd0);
    check_hex("rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    // ENTER and CLEAR in IDLE are ignored without err
    press(4'd14);
    check("idle_enter_err", {15'd0, bus.err}, 16'd0);
    check("idle_enter_valid", {15'd0, bus.word_valid}, 16'd0);
    press(4'd12);
    check("idle_clear_err", {15'd0, bus.err}, 16'd0);
    check("idle_clear_count", {13'd0, bus.digit_count}, 16'd0);

    // 1,0,A,D then ENTER -> 10AD
    press(4'd0); press(4'd13); press(4'd3); press(4'd15);
    check("10ad_word", bus.word, 16'h10AD);
    check("10ad_count", {13'd0, bus.digit_count}, 16'd4);
    check("10ad_valid_pre", {15'd0, bus.word_valid}, 16'd0);
    press(4'd14);
    check("10ad_valid", {15'd0, bus.word_valid}, 16'd1);
    check("10ad_word_hold", bus.word, 16'h10AD);
    check_hex("10ad", 7'h79, 7'h40, 7'h08, 7'h21);

    // Hold 5 cycles without ready, then a rejected key
    repeat (5) @(negedge clk);
    check("hold_valid", {15'd0, bus.word_valid}, 16'd1);
    press(4'd0);
    check("hold_key_err", {15'd0, bus.err}, 16'd1);
    check("hold_key_word", bus.word, 16'h10AD);
    check("hold_key_valid", {15'd0, bus.word_valid}, 16'd1);
    @(negedge clk);
    check("hold_err_pulse", {15'd0, bus.err}, 16'd0);
    handshake();
    check("hs_valid", {15'd0, bus.word_valid}, 16'd0);
    check("hs_count", {13'd0, bus.digit_count}, 16'd0);
    check("hs_word", bus.word, 16'h0000);

    // 4,5 then ENTER -> 0045 with two lit digits
    press(4'd4); press(4'd5); press(4'd14);
    check("45_word", bus.word, 16'h0045);
    check("45_count", {13'd0, bus.digit_count}, 16'd2);
    @(negedge clk);
    check_hex("45", 7'h7F, 7'h7F, 7'h19, 7'h12);

    // Key together with ready in HOLD: handshake done, key dropped, err
    @(negedge clk);
    bus.key_valid  = 1'b1;
    bus.key_code   = 4'd1;
    bus.word_ready = 1'b1;
    @(negedge clk);
    bus.key_valid  = 1'b0;
    bus.word_ready = 1'b0;
    check("hsk_err", {15'd0, bus.err}, 16'd1);
    check("hsk_valid", {15'd0, bus.word_valid}, 16'd0);
    check("hsk_word", bus.word, 16'h0000);
    check("hsk_count", {13'd0, bus.digit_count}, 16'd0);

    // 1,2,3,4 then a fifth digit is rejected
    press(4'd0); press(4'd1); press(4'd2); press(4'd4);
    check("full_word", bus.word, 16'h1234);
    check("full_err_pre", {15'd0, bus.err}, 16'd0);
    press(4'd5);
    check("full_err", {15'd0, bus.err}, 16'd1);
    check("full_word_keep", bus.word, 16'h1234);
    check("full_count", {13'd0, bus.digit_count}, 16'd4);
    @(negedge clk);
    check("full_err_pulse", {15'd0, bus.err}, 16'd0);
`ifdef ENTRY_BACKSPACE_EN
    // BACKSPACE from FULL returns to COLLECT so another digit is accepted
    press(4'd12);
    check("full_bs_word", bus.word, 16'h0123);
    check("full_bs_count", {13'd0, bus.digit_count}, 16'd3);
    press(4'd9);
    check("full_bs_redo_err", {15'd0, bus.err}, 16'd0);
    check("full_bs_redo_word", bus.word, 16'h1238);
`else
    press(4'd12);
    check("full_clr_word", bus.word, 16'h0000);
    check("full_clr_count", {13'd0, bus.digit_count}, 16'd0);
`endif

    // 1,2,3 then code 12
    do_reset();
    press(4'd0); press(4'd1); press(4'd2);
    check("123_word", bus.word, 16'h0123);
    press(4'd12);
    check_hex("c12_lag", 7'h7F, 7'h79, 7'h24, 7'h30);
`ifdef ENTRY_BACKSPACE_EN
    check("bs_word", bus.word, 16'h0012);
    check("bs_count", {13'd0, bus.digit_count}, 16'd2);
    @(negedge clk);
    check_hex("bs", 7'h7F, 7'h7F, 7'h79, 7'h24);
    press(4'd12); press(4'd12);
    check("bs_zero_count", {13'd0, bus.digit_count}, 16'd0);
    press(4'd12);
    check("bs_idle_err", {15'd0, bus.err}, 16'd0);
    check("bs_idle_word", bus.word, 16'h0000);
`else
    check("clr_word", bus.word, 16'h0000);
    check("clr_count", {13'd0, bus.digit_count}, 16'd0);
    @(negedge clk);
    check_hex("clr", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
`endif

    // Reset in HOLD beats word_ready and key_valid
    press(4'd8); press(4'd14);
    check("rh_valid_pre", {15'd0, bus.word_valid}, 16'd1);
    check("rh_word_pre", bus.word, 16'h0007);
    @(negedge clk);
    reset          = 1'b1;
    bus.word_ready = 1'b1;
    bus.key_valid  = 1'b1;
    bus.key_code   = 4'd0;
    @(negedge clk);
    reset          = 1'b0;
    bus.word_ready = 1'b0;
    bus.key_valid  = 1'b0;
    check("rh_valid", {15'd0, bus.word_valid}, 16'd0);
    check("rh_word", bus.word, 16'h0000);
    check("rh_count", {13'd0, bus.digit_count}, 16'd0);
    check("rh_err", {15'd0, bus.err}, 16'd0);
    check_hex("rh", 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
